alu_decode_stage: RTL and testbench
===================================

# alu_decode_stage

Decode-and-issue stage that produces the operand and control inputs of the ALU: `a`, `b`, `op`, `mod`. It accepts one 32-bit RV32I instruction per cycle, together with the fetched register values and PC, over a valid/ready handshake. It decodes OP, OP-IMM, LUI and AUIPC into registered ALU controls plus a writeback descriptor. It sits between register-file read and the combinational ALU; its outputs drive the ALU ports directly.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous discard of all buffered entries
- `in_valid`  in  1  instruction bundle present
- `in_ready`  out  1  stage accepts the bundle this cycle
- `in_instr`  in  32  instruction word
- `in_pc`  in  32  instruction address
- `in_rs1_data`  in  32  value of register rs1
- `in_rs2_data`  in  32  value of register rs2
- `out_valid`  out  1  decoded bundle present
- `out_ready`  in  1  consumer takes the bundle
- `out_a`, `out_b`  out  32  ALU operands
- `out_op`  out  3  ALU op: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SR, 6 OR, 7 AND
- `out_mod`  out  1  arithmetic-shift modifier
- `out_rd`  out  5  destination register
- `out_we`  out  1  writeback enable
- `out_illegal`  out  1  instruction not decodable by this stage

## Operation
- Handshakes:
  - Input transfer occurs when `in_valid && in_ready`.
  - Output transfer occurs when `out_valid && out_ready`.
  - Payload is held stable while `out_valid && !out_ready`.
- Decode by opcode `instr[6:0]`. `op` is `funct3` unless stated otherwise.
- **OP, 0110011:**
  - `a = rs1`.
  - `funct7` `0000000` is legal for all `funct3`. `0100000` is legal only for `funct3` 0 and 5; any other `funct7` is illegal.
  - SUB (`funct3` 0, `funct7` `0100000`): `op` = ADD, `b = ~rs2 + 1`, truncated to 32 bits.
  - Shifts (`funct3` 1 and 5): `b = {27'b0, rs2[4:0]}`.
  - Otherwise `b = rs2`.
  - `mod = instr[30]` when `funct3` = 5, else 0.
- **OP-IMM, 0010011:**
  - `a = rs1`.
  - Non-shifts: `b` = sign-extended `instr[31:20]`.
  - Shifts (`funct3` 1 and 5): `b = {27'b0, instr[24:20]}`, `mod = instr[30]` for `funct3` 5.
  - `instr[31:25]` must be `0000000`, or `0100000` for `funct3` 5 only; otherwise illegal.
- **LUI, 0110111:** `a = 0`, `b = {instr[31:12], 12'b0}`, `op` = ADD.
- **AUIPC, 0010111:** `a = pc`, `b = {instr[31:12], 12'b0}`, `op` = ADD.
- **Any other opcode, or an illegal encoding above:** `out_illegal = 1`, `out_we = 0`, `a = b = 0`, `op` = ADD, `mod = 0`, `out_rd = instr[11:7]`.
- `out_rd = instr[11:7]`.
- `out_we = !illegal && (rd != 0)`.
- Illegal bundles still traverse the handshake; the stage never stalls on them.

## Timing
- Reset:
  - `out_valid = 0`.
  - All payload outputs are 0.
  - `in_ready = 1`.
  - Buffered entries are discarded immediately, including mid-stall.
- Latency: exactly 1 cycle. A bundle accepted at edge N is on the outputs with `out_valid = 1` after edge N.
- Throughput: one bundle per cycle while `out_ready` is held high.
- `flush`:
  - At the edge it clears all entries: `out_valid = 0` next cycle.
  - It takes priority over a same-cycle input transfer; that bundle is dropped.
  - `in_ready` is unaffected in the flush cycle.
- Simultaneous input and output transfer in the same cycle: the new bundle replaces the departing one, with no bubble.

## Configuration
- Macro `ALU_DECODE_SKID_EN`.
- Defined:
  - Two-entry skid buffer.
  - `in_ready` is a register output: `in_ready = !skid_valid`, so there is no combinational path from `out_ready` to `in_ready`.
  - On a stall, the one bundle already in flight lands in the skid entry.
  - The skid entry drains to the output before new input is accepted.
- Undefined:
  - Single output register.
  - `in_ready = !out_valid || out_ready`, a combinational pass-through.
- Both builds have identical decode results, latency, ordering and flush behaviour.

## Test plan
- Reset then ADDI: `in_instr = 0x00500093`, `rs1 = 7` -> next cycle `out_valid = 1`, `a = 7`, `b = 5`, `op = 0`, `mod = 0`, `rd = 1`, `we = 1`.
- SUB: `in_instr = 0x40208133`, `rs1 = 10`, `rs2 = 3` -> `op = 0`, `b = 0xFFFFFFFD`, `we = 1`, `rd = 2`.
- SRAI then SLL:
  - SRAI `0x4041D193` -> `op = 5`, `mod = 1`, `b = 4`.
  - SLL with `rs2 = 0x00000123` -> `op = 1`, `b = 0x3`.
- Illegal cases:
  - SLLI with `instr[30] = 1` (`0x40109093`) -> `illegal = 1`, `we = 0`.
  - Opcode `0x73` -> `illegal = 1`.
  - LUI to `x0` (`0x12345037`) -> `b = 0x12345000`, `we = 0`, `illegal = 0`.
- Backpressure: stream 4 bundles with `out_ready` low for 3 cycles mid-stream. Required: all 4 delivered in order, none lost or duplicated. With `ALU_DECODE_SKID_EN`, `in_ready` drops exactly one cycle after the stall begins.
- Flush and reset: assert `flush` with a bundle held stalled and a new input transferring -> `out_valid = 0` next cycle, both bundles dropped. Pulse `reset` asynchronously mid-stall -> all outputs 0 immediately, `in_ready = 1`.

Source files
------------

// File: rtl/alu_decode_stage.sv
// RV32I decode/issue stage feeding the ALU: OP, OP-IMM, LUI and AUIPC become registered a/b/op/mod plus rd/we.
// Build option ALU_DECODE_SKID_EN selects a two-entry skid buffer with a registered in_ready.
module alu_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [2:0]  out_op,
    output logic        out_mod,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SLL = 3'd1;
    localparam logic [2:0] F3_SR  = 3'd5;

    typedef struct packed {
        logic signed [31:0] a;
        logic signed [31:0] b;
        logic [2:0]         op;
        logic               mod;
        logic [4:0]         rd;
        logic               we;
        logic               illegal;
    } bundle_t;

    function automatic logic signed [31:0] negate(input logic [31:0] v);
        return -$signed(v);
    endfunction

    function automatic logic signed [31:0] sext12(input logic [11:0] imm);
        return {{20{imm[11]}}, imm};
    endfunction

    function automatic logic signed [31:0] shamt(input logic [4:0] sh);
        return {27'b0, sh};
    endfunction

    function automatic logic signed [31:0] upper20(input logic [19:0] imm);
        return {imm, 12'b0};
    endfunction

    function automatic bundle_t decode(
        input logic [31:0] instr,
        input logic [31:0] pc,
        input logic [31:0] rs1,
        input logic [31:0] rs2
    );
        bundle_t    d;
        logic [6:0] opcode;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       is_shift;
        logic       legal;

        opcode   = instr[6:0];
        f3       = instr[14:12];
        f7       = instr[31:25];
        is_shift = (f3 == F3_SLL) || (f3 == F3_SR);
        d        = '0;
        d.rd     = instr[11:7];
        legal    = 1'b0;

        case (opcode)
            OPC_OP: begin
                legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
                d.a   = $signed(rs1);
                d.op  = f3;
                if ((f3 == F3_ADD) && (f7 == F7_ALT))
                    d.b = negate(rs2);
                else if (is_shift)
                    d.b = shamt(rs2[4:0]);
                else
                    d.b = $signed(rs2);
                d.mod = (f3 == F3_SR) && instr[30];
            end
            OPC_OP_IMM: begin
                // Only the shift forms reuse imm[11:5] as a funct7 field.
                legal = !is_shift || (f7 == F7_BASE) || ((f7 == F7_ALT) && (f3 == F3_SR));
                d.a   = $signed(rs1);
                d.op  = f3;
                d.b   = is_shift ? shamt(instr[24:20]) : sext12(instr[31:20]);
                d.mod = (f3 == F3_SR) && instr[30];
            end
            OPC_LUI: begin
                legal = 1'b1;
                d.b   = upper20(instr[31:12]);
            end
            OPC_AUIPC: begin
                legal = 1'b1;
                d.a   = $signed(pc);
                d.b   = upper20(instr[31:12]);
            end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            d.a   = '0;
            d.b   = '0;
            d.op  = F3_ADD;
            d.mod = 1'b0;
        end
        d.illegal = !legal;
        d.we      = legal && (d.rd != 5'd0);
        return d;
    endfunction

    bundle_t dec_p0;
    bundle_t bundle_p1;
    logic    vld_p1;
    logic    in_fire;

    assign dec_p0  = decode(in_instr, in_pc, in_rs1_data, in_rs2_data);
    assign in_fire = in_valid && in_ready;

`ifdef ALU_DECODE_SKID_EN
    bundle_t skid_p1;
    logic    skid_vld_p1;

    // in_ready comes straight from a flop, so out_ready never reaches it combinationally.
    assign in_ready = !skid_vld_p1;

    // ---- p0 -> p1: output register with skid entry ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            bundle_p1   <= '0;
        end else if (flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (!vld_p1 || out_ready) begin
            if (skid_vld_p1) begin
                bundle_p1   <= skid_p1;
                vld_p1      <= 1'b1;
                skid_vld_p1 <= 1'b0;
            end else if (in_fire) begin
                bundle_p1 <= dec_p0;
                vld_p1    <= 1'b1;
            end else begin
                vld_p1 <= 1'b0;
            end
        end else if (in_fire) begin
            skid_vld_p1 <= 1'b1;
        end
    end

    // Skid payload is qualified by skid_vld_p1, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_fire && vld_p1 && !out_ready)
            skid_p1 <= dec_p0;
    end
`else
    assign in_ready = !vld_p1 || out_ready;

    // ---- p0 -> p1: single output register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            bundle_p1 <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (in_fire) begin
            bundle_p1 <= dec_p0;
            vld_p1    <= 1'b1;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end
`endif

    assign out_valid   = vld_p1;
    assign out_a       = $unsigned(bundle_p1.a);
    assign out_b       = $unsigned(bundle_p1.b);
    assign out_op      = bundle_p1.op;
    assign out_mod     = bundle_p1.mod;
    assign out_rd      = bundle_p1.rd;
    assign out_we      = bundle_p1.we;
    assign out_illegal = bundle_p1.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed decode cases, backpressure, flush, reset and random traffic vs. a queue model.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data;
    logic [31:0] out_a, out_b;
    logic [2:0]  out_op;
    logic        out_mod, out_we, out_illegal;
    logic [4:0]  out_rd;

    always #5 clk = ~clk;

    alu_decode_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_mod(out_mod),
        .out_rd(out_rd), .out_we(out_we), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic        mod;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   delivered = 0;
    bit   in_fired;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode written straight from the ISA rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         shift;
        bit         ok;
        f3    = ins[14:12];
        f7    = ins[31:25];
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        e     = '0;
        e.rd  = ins[11:7];
        ok    = 1'b0;
        case (ins[6:0])
            7'h33: begin
                ok   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.a  = r1;
                e.op = f3;
                if (f3 == 3'd0 && f7 == 7'h20) e.b = 32'd0 - r2;
                else if (shift)                e.b = r2 % 32;
                else                           e.b = r2;
                e.mod = (f3 == 3'd5) && (f7 == 7'h20);
            end
            7'h13: begin
                ok   = !shift || (f7 == 7'h00) || (f7 == 7'h20 && f3 == 3'd5);
                e.a  = r1;
                e.op = f3;
                e.b  = shift ? 32'(ins[24:20]) : 32'($signed(ins[31:20]));
                e.mod = (f3 == 3'd5) && (f7 == 7'h20);
            end
            7'h37: begin ok = 1'b1; e.b = ins & 32'hFFFF_F000; end
            7'h17: begin ok = 1'b1; e.a = pc; e.b = ins & 32'hFFFF_F000; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.a = 0; e.b = 0; e.op = 0; e.mod = 0;
        end
        e.illegal = !ok;
        e.we      = ok && (e.rd != 0);
        return e;
    endfunction

    // One clock: check against the model at negedge, update it, then return at posedge+1.
    task automatic cycle();
        @(negedge clk);
        check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
`ifdef ALU_DECODE_SKID_EN
        check_eq("in_ready", 32'(in_ready), 32'(q.size() < 2));
`else
        check_eq("in_ready", 32'(in_ready), 32'((q.size() == 0) || out_ready));
`endif
        if (q.size() > 0) begin
            check_eq("a", out_a, q[0].a);
            check_eq("b", out_b, q[0].b);
            check_eq("op", 32'(out_op), 32'(q[0].op));
            check_eq("mod", 32'(out_mod), 32'(q[0].mod));
            check_eq("rd", 32'(out_rd), 32'(q[0].rd));
            check_eq("we", 32'(out_we), 32'(q[0].we));
            check_eq("illegal", 32'(out_illegal), 32'(q[0].illegal));
        end
        in_fired = in_valid && in_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && out_ready) begin
                void'(q.pop_front());
                delivered++;
            end
            if (in_fired) q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_a"}, out_a, 32'd0);
        check_eq({tag, "_b"}, out_b, 32'd0);
        check_eq({tag, "_ctl"}, {22'd0, out_op, out_mod, out_rd, out_we, out_illegal}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c;
        int d0;
        logic [31:0] ins;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 0; in_pc = 0; in_rs1_data = 0; in_rs2_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        reset = 1'b0;

        // Directed decode cases
        send(32'h0050_0093, 32'h100, 32'd7, 32'd0);
        check_eq("addi_valid", 32'(out_valid), 32'd1);
        check_eq("addi_a", out_a, 32'd7);
        check_eq("addi_b", out_b, 32'd5);
        check_eq("addi_op", 32'(out_op), 32'd0);
        check_eq("addi_mod", 32'(out_mod), 32'd0);
        check_eq("addi_rd", 32'(out_rd), 32'd1);
        check_eq("addi_we", 32'(out_we), 32'd1);

        send(32'h4020_8133, 32'h104, 32'd10, 32'd3);
        check_eq("sub_op", 32'(out_op), 32'd0);
        check_eq("sub_b", out_b, 32'hFFFF_FFFD);
        check_eq("sub_we", 32'(out_we), 32'd1);
        check_eq("sub_rd", 32'(out_rd), 32'd2);

        send(32'h4041_D193, 32'h108, 32'h8000_0000, 32'd0);
        check_eq("srai_op", 32'(out_op), 32'd5);
        check_eq("srai_mod", 32'(out_mod), 32'd1);
        check_eq("srai_b", out_b, 32'd4);

        send(32'h0020_9233, 32'h10C, 32'd1, 32'h0000_0123);
        check_eq("sll_op", 32'(out_op), 32'd1);
        check_eq("sll_b", out_b, 32'd3);

        send(32'h4010_9093, 32'h110, 32'd1, 32'd2);
        check_eq("slli30_illegal", 32'(out_illegal), 32'd1);
        check_eq("slli30_we", 32'(out_we), 32'd0);

        send(32'h0000_0073, 32'h114, 32'd1, 32'd2);
        check_eq("sys_illegal", 32'(out_illegal), 32'd1);
        check_eq("sys_ab", out_a | out_b, 32'd0);

        send(32'h1234_5037, 32'h118, 32'd9, 32'd9);
        check_eq("lui_b", out_b, 32'h1234_5000);
        check_eq("lui_we", 32'(out_we), 32'd0);
        check_eq("lui_illegal", 32'(out_illegal), 32'd0);
        cycle();

        // Backpressure: 4 bundles, out_ready low for cycles 2..4
        d0 = delivered;
        k  = 0;
        for (c = 0; c < 30 && (k < 4 || q.size() > 0); c++) begin
            out_ready   = !(c >= 2 && c < 5);
            in_valid    = (k < 4);
            in_instr    = {12'(k + 1), 5'd1, 3'd0, 5'(k + 5), 7'h13};
            in_pc       = 32'h200 + 32'(4 * k);
            in_rs1_data = 32'(1000 * k);
            in_rs2_data = 32'd0;
`ifdef ALU_DECODE_SKID_EN
            if (c == 2) check_eq("bp_ready_stall_start", 32'(in_ready), 32'd1);
            if (c == 3) check_eq("bp_ready_after_stall", 32'(in_ready), 32'd0);
`endif
            cycle();
            if (in_fired) k++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check_eq("bp_accepted", 32'(k), 32'd4);
        check_eq("bp_delivered", 32'(delivered - d0), 32'd4);

        // Flush with a stalled bundle and a new input offered
        out_ready = 1'b0;
        send(32'h0010_0113, 32'h300, 32'd1, 32'd0);
        in_valid = 1'b1; in_instr = 32'h0020_0193; flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        cycle();
        out_ready = 1'b1;
        cycle();

        // Asynchronous reset mid-stall
        out_ready = 1'b0;
        send(32'h0030_0213, 32'h400, 32'd5, 32'd0);
        send(32'h0040_0293, 32'h404, 32'd6, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check_idle_zero("async_reset");
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 4))
                0: ins = {7'h00, 18'($urandom), 7'h33};
                1: ins = {25'($urandom), 7'h13};
                2: ins = {25'($urandom), 7'h37};
                3: ins = {25'($urandom), 7'h17};
                default: ins = $urandom;
            endcase
            if ($urandom_range(0, 2) == 0) ins[31:25] = 7'h20;
            else if ($urandom_range(0, 3) == 0) ins[31:25] = 7'($urandom);
            in_valid    = ($urandom_range(0, 9) < 8);
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 49) == 0);
            in_instr    = ins;
            in_pc       = $urandom;
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        check_eq("final_out_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
